// File: rtl/muxn_pkg.sv
// Shared types and constants for the synchronous N-way output multiplexer.
package muxn_pkg;

  typedef enum logic {
    RUN = 1'b0,
    GAP = 1'b1
  } state_t;

  localparam int unsigned CNT_W = 4;

  // Select width: max(1, clog2(n))
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/muxn_sync_if.sv
// Data/selection bus of muxn_sync; master drives data and requests, slave returns z and status.
interface muxn_sync_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  import muxn_pkg::*;

  localparam int unsigned SW = sel_w(N);

  logic [N*W-1:0] d;
  logic           sel_req;
  logic [SW-1:0]  sel_in;
  logic           sel_ack;
  logic           sel_err;
  logic [SW-1:0]  sel_cur;
  logic [W-1:0]   z;
  logic           z_valid;

  modport master (
    output d, sel_req, sel_in,
    input  sel_ack, sel_err, sel_cur, z, z_valid
  );

  modport slave (
    input  d, sel_req, sel_in,
    output sel_ack, sel_err, sel_cur, z, z_valid
  );

endinterface

// File: rtl/muxn_gap_cnt.sv
// Dead-cycle counter for channel switches: loads GAP_CYC, counts down, flags the final decrement.
module muxn_gap_cnt
  import muxn_pkg::*;
#(
  parameter int unsigned GAP_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(GAP_CYC);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // High when the current decrement brings the count to zero
  assign zero_c = (cnt == CNT_W'(1));

endmodule

// File: rtl/muxn_sync.sv
// Registered N-way multiplexer with handshaked channel switching and a fixed dead gap per switch.
// Build option: define MUXN_HOLD_EN to hold the last z during the gap instead of driving zero.
module muxn_sync
  import muxn_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned GAP_CYC = 2,
  parameter int unsigned RST_SEL = 0
) (
  input  logic        clk,
  input  logic        rst,
  muxn_sync_if.slave  bus
);

  localparam int unsigned SW = sel_w(N);

  state_t         state, state_nxt;
  logic [SW-1:0]  cur, cur_nxt;
  logic [SW-1:0]  pend, pend_nxt;
  logic [W-1:0]   z_q, z_nxt;
  logic           zv_q, zv_nxt;
  logic           ack_q, ack_nxt;
  logic           err_q, err_nxt;
  logic           accept_c;
  logic           in_range_c;
  logic           gap_load;
  logic           gap_dec;
  logic           gap_zero_c;
  logic [W-1:0]   ch [N];

  for (genvar k = 0; k < N; k++) begin : g_ch
    assign ch[k] = bus.d[k*W +: W];
  end

  muxn_gap_cnt #(
    .GAP_CYC (GAP_CYC)
  ) u_gap_cnt (
    .clk    (clk),
    .rst    (rst),
    .load   (gap_load),
    .dec    (gap_dec),
    .zero_c (gap_zero_c)
  );

  // A fresh ack blocks acceptance so that a held request is never acked twice in a row
  assign accept_c   = (state == RUN) && bus.sel_req && !ack_q;
  assign in_range_c = (32'(bus.sel_in) < N);

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    pend_nxt  = pend;
    z_nxt     = z_q;
    zv_nxt    = 1'b0;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;

    if (state == RUN) begin
      z_nxt  = ch[cur];
      zv_nxt = 1'b1;
      if (accept_c) begin
        ack_nxt = 1'b1;
        err_nxt = !in_range_c;
        if (in_range_c && (bus.sel_in != cur)) begin
          pend_nxt  = bus.sel_in;
          state_nxt = GAP;
          gap_load  = 1'b1;
        end
      end
    end else begin
`ifdef MUXN_HOLD_EN
      z_nxt = z_q;
`else
      z_nxt = '0;
`endif
      gap_dec = 1'b1;
      if (gap_zero_c) begin
        cur_nxt   = pend;
        state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cur   <= SW'(RST_SEL);
      pend  <= SW'(RST_SEL);
      z_q   <= '0;
      zv_q  <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      pend  <= pend_nxt;
      z_q   <= z_nxt;
      zv_q  <= zv_nxt;
      ack_q <= ack_nxt;
      err_q <= err_nxt;
    end
  end

  assign bus.z       = z_q;
  assign bus.z_valid = zv_q;
  assign bus.sel_ack = ack_q;
  assign bus.sel_err = err_q;
  assign bus.sel_cur = cur;

endmodule

// File: doc/muxn_sync.md
MUXN_SYNC -- requirements
Module: muxn_sync

Interface
REQ-001 The block SHALL have parameter N, default 4, number of data channels (2..16).
REQ-002 The block SHALL have parameter W, default 8, data width per channel (1..64).
REQ-003 The block SHALL have parameter GAP_CYC, default 2, dead cycles inserted on a channel switch (1..15).
REQ-004 The block SHALL have parameter RST_SEL, default 0, channel selected out of reset (0..N-1).
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port d, input, N*W, channel data packed, channel k at bits [k*W +: W].
REQ-008 The block SHALL have port sel_req, input, 1, request to switch channel.
REQ-009 The block SHALL have port sel_in, input, SW = max(1,$clog2(N)), requested channel.
REQ-010 The block SHALL have port sel_ack, output, 1, one-cycle pulse: request accepted.
REQ-011 The block SHALL have port sel_err, output, 1, one-cycle pulse: accepted request had sel_in >= N.
REQ-012 The block SHALL have port sel_cur, output, SW, currently active channel.
REQ-013 The block SHALL have port z, output, W, registered multiplexer output.
REQ-014 The block SHALL have port z_valid, output, 1, z carries data of sel_cur.

Function
REQ-015 States SHALL be RUN and GAP only.
REQ-016 In RUN, each rising edge SHALL load z <= d[sel_cur] and z_valid <= 1 (latency 1 cycle).
REQ-017 sel_req SHALL be accepted only when state is RUN; sel_ack pulses for exactly the cycle after acceptance.
REQ-018 Accepted sel_in == sel_cur SHALL ack, stay in RUN, z uninterrupted.
REQ-019 Accepted sel_in >= N SHALL ack, pulse sel_err with sel_ack, leave sel_cur and state unchanged.
REQ-020 Accepted valid sel_in != sel_cur SHALL latch sel_in as pending, enter GAP, load gap counter with GAP_CYC.
REQ-021 In GAP, z_valid SHALL be 0 and the counter SHALL decrement each cycle.
REQ-022 When counter reaches 0, sel_cur SHALL take pending value and state return to RUN on the same edge; first z of new channel appears the next edge.
REQ-023 Total z_valid low time per switch SHALL be exactly GAP_CYC cycles.
REQ-024 sel_req in GAP SHALL be ignored, no ack; requester holds sel_req until sel_ack.
REQ-025 sel_ack and sel_err SHALL never be high for two consecutive cycles.
REQ-026 Changes on d SHALL never affect state, only z.

Reset
REQ-027 While rst=1: z=0, z_valid=0, sel_ack=0, sel_err=0, sel_cur=RST_SEL, state RUN, counter 0, pending RST_SEL.
REQ-028 rst asserted mid-GAP SHALL discard pending selection immediately.
REQ-029 First rising edge after rst deasserts SHALL load z=d[RST_SEL], z_valid=1; requests on that edge are accepted.

Configuration
REQ-030 Macro MUXN_HOLD_EN defined: z SHALL hold its last RUN value throughout GAP.
REQ-031 MUXN_HOLD_EN undefined: z SHALL be driven 0 throughout GAP.
REQ-032 z_valid, sel_ack, timing SHALL be identical in both builds.

Structure
REQ-033 Package muxn_pkg SHALL hold the state enum (RUN, GAP), counter width constant (4 bits) and the SW width function.
REQ-034 Gap counter SHALL be sub-module muxn_gap_cnt (load, decrement, zero flag); selection datapath stays in muxn_sync.

Verification (N=4, W=8, GAP_CYC=2, RST_SEL=0)
REQ-035 Reset, d={8'h44,8'h33,8'h22,8'h11}, release -> next edge z=8'h11, z_valid=1, sel_cur=0.
REQ-036 sel_req=1, sel_in=2 in RUN -> sel_ack 1 cycle, z_valid=0 two cycles, sel_cur=2, then z=8'h33.
REQ-037 sel_in=2 while sel_cur=2 -> sel_ack pulse, z_valid stays 1, z=8'h33 continuous.
REQ-038 Re-request sel_in=1 during GAP -> no ack until RUN; then ack and second gap of 2 cycles.
REQ-039 rst pulse mid-GAP toward channel 3 -> sel_cur=0, z=0 immediately; after release z=8'h11.
REQ-040 Both builds, switch 0->1 -> GAP z=8'h11 with MUXN_HOLD_EN, z=8'h00 without; z_valid identical.
